// File: rtl/min_hardware.sv
// Row-parallel Sobel edge detector: classifies every column of the middle row as edge/background.
// Latency 1 clock (combinational Sobel + output register); no backpressure, a new row every clock.
module min_hardware #(
    parameter int          WIDTH     = 320,
    parameter logic [10:0] THRESHOLD = 11'd200,
    parameter logic [7:0]  EDGE_VAL  = 8'hFF,
    parameter logic [7:0]  BG_VAL    = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in1 [0:WIDTH-1],
    input  logic [7:0] in2 [0:WIDTH-1],
    input  logic [7:0] in3 [0:WIDTH-1],
    output logic [7:0] out [0:WIDTH-1]
);

    logic [7:0] out_d [0:WIDTH-1];
    logic [7:0] out_q [0:WIDTH-1];

    // Border columns have no full 3x3 window and are never classified.
    assign out_d[0]       = BG_VAL;
    assign out_d[WIDTH-1] = BG_VAL;

    for (genvar x = 1; x < WIDTH - 1; x++) begin : g_col
        logic [9:0]         gx_pos, gx_neg, gy_pos, gy_neg;
        logic signed [11:0] gx, gy;
        logic [10:0]        abs_gx, abs_gy, mag;

        assign gx_pos = 10'(in1[x+1]) + 10'({in2[x+1], 1'b0}) + 10'(in3[x+1]);
        assign gx_neg = 10'(in1[x-1]) + 10'({in2[x-1], 1'b0}) + 10'(in3[x-1]);
        assign gy_pos = 10'(in3[x-1]) + 10'({in3[x],   1'b0}) + 10'(in3[x+1]);
        assign gy_neg = 10'(in1[x-1]) + 10'({in1[x],   1'b0}) + 10'(in1[x+1]);

        assign gx = $signed({2'b00, gx_pos}) - $signed({2'b00, gx_neg});
        assign gy = $signed({2'b00, gy_pos}) - $signed({2'b00, gy_neg});

        // |G| <= 1020, so the magnitude of each term fits in 11 bits and the sum (<= 2040) too.
        assign abs_gx = gx[11] ? 11'(-gx) : gx[10:0];
        assign abs_gy = gy[11] ? 11'(-gy) : gy[10:0];
        assign mag    = abs_gx + abs_gy;

        assign out_d[x] = (mag > THRESHOLD) ? EDGE_VAL : BG_VAL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int x = 0; x < WIDTH; x++) out_q[x] <= BG_VAL;
        end else begin
            for (int x = 0; x < WIDTH; x++) out_q[x] <= out_d[x];
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_min_hardware.sv
// Directed bench for min_hardware: hand-derived edge rows checked column by column.
module tb_min_hardware;

    localparam int W = 320;

    logic       clk;
    logic       rst_n;
    logic [7:0] in1  [0:W-1];
    logic [7:0] in2  [0:W-1];
    logic [7:0] in3  [0:W-1];
    logic [7:0] dout [0:W-1];
    logic [7:0] exp_row [0:W-1];

    int n_tests = 0;
    int n_fail  = 0;

    min_hardware dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in1   (in1),
        .in2   (in2),
        .in3   (in3),
        .out   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    task automatic check_row(input string tag);
        for (int x = 0; x < W; x++) chk($sformatf("%s[%0d]", tag, x), dout[x], exp_row[x]);
    endtask

    task automatic fill_all(input logic [7:0] v1, input logic [7:0] v2, input logic [7:0] v3);
        for (int x = 0; x < W; x++) begin
            in1[x] = v1;
            in2[x] = v2;
            in3[x] = v3;
        end
    endtask

    // All three rows: lo for x < 160, hi for x >= 160.
    task automatic vstep(input logic [7:0] lo, input logic [7:0] hi);
        for (int x = 0; x < W; x++) begin
            in1[x] = (x < 160) ? lo : hi;
            in2[x] = (x < 160) ? lo : hi;
            in3[x] = (x < 160) ? lo : hi;
        end
    endtask

    task automatic exp_fill(input logic [7:0] v);
        for (int x = 0; x < W; x++) exp_row[x] = v;
    endtask

    task automatic exp_hstep();
        for (int x = 0; x < W; x++) exp_row[x] = (x == 0 || x == W - 1) ? 8'h00 : 8'hFF;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int x = 0; x < W; x++) begin
            in1[x] = 8'($urandom);
            in2[x] = 8'($urandom);
            in3[x] = 8'($urandom);
        end
        #2;
        exp_fill(8'h00);
        check_row("reset_noclk");

        // Release reset, uniform mid-grey rows.
        @(negedge clk);
        rst_n = 1'b1;
        fill_all(8'h80, 8'h80, 8'h80);
        step();
        exp_fill(8'h00);
        check_row("uniform");

        // Vertical step 0x00 -> 0xFF: |Gx| = 1020 at 159 and 160.
        vstep(8'h00, 8'hFF);
        step();
        exp_fill(8'h00);
        exp_row[159] = 8'hFF;
        exp_row[160] = 8'hFF;
        check_row("vstep");

        // Horizontal step: bottom row bright.
        fill_all(8'h00, 8'h00, 8'hFF);
        step();
        exp_hstep();
        check_row("hstep");

        // Step height 50: mag = 200, equal to threshold -> background.
        vstep(8'h00, 8'h32);
        step();
        exp_fill(8'h00);
        check_row("thr_eq");

        // Step height 51: mag = 204 -> edge.
        vstep(8'h00, 8'h33);
        step();
        exp_fill(8'h00);
        exp_row[159] = 8'hFF;
        exp_row[160] = 8'hFF;
        check_row("thr_gt");

        // Middle-row impulse 0xFF at 100: |Gx| = 510 at 99 and 101, centre unused at 100.
        fill_all(8'h00, 8'h00, 8'h00);
        in2[100] = 8'hFF;
        step();
        exp_fill(8'h00);
        exp_row[99]  = 8'hFF;
        exp_row[101] = 8'hFF;
        check_row("impulse_mid");

        // Top-row impulse 100 at 100: mag = 200 at 99,100,101 (mixed-sign Gx/Gy) -> background.
        fill_all(8'h00, 8'h00, 8'h00);
        in1[100] = 8'd100;
        step();
        exp_fill(8'h00);
        check_row("impulse_top_eq");

        // Top-row impulse 101: mag = 202 at 99,100,101 -> edge.
        in1[100] = 8'd101;
        step();
        exp_row[99]  = 8'hFF;
        exp_row[100] = 8'hFF;
        exp_row[101] = 8'hFF;
        check_row("impulse_top_gt");

        // Latency: row A registered, row B applied mid-cycle must not show until the next edge.
        vstep(8'h00, 8'hFF);
        step();
        fill_all(8'h00, 8'h00, 8'hFF);
        #2;
        exp_fill(8'h00);
        exp_row[159] = 8'hFF;
        exp_row[160] = 8'hFF;
        check_row("stream_hold");
        step();
        exp_hstep();
        check_row("stream_next");

        // Mid-stream reset on an edge-rich row clears the output without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        exp_fill(8'h00);
        check_row("midreset");
        step();
        check_row("midreset_edge");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        exp_hstep();
        check_row("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
